// File: rtl/instr_fetch.sv
// Instruction fetch: one-word buffer between instruction memory and decode.
// Presents halfword-addressed instructions and refetches only on a word change.
module instr_fetch #(
    parameter int                WIDTH    = 32,
    parameter int                PC_W     = 16,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             mem_rd,
    output logic [PC_W-2:0]  mem_addr,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_valid,
    output logic             en,
    output logic [WIDTH-1:0] long_instr,
    output logic             instr_choose,
    output logic [PC_W-1:0]  pc,
    input  logic             done,
    input  logic             jump_en,
    input  logic [PC_W-1:0]  jump_addr
);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, WAIT} state_t;

    state_t           state_q, state_d;
    logic             arm_q, arm_d;
    logic [PC_W-1:0]  pc_q, pc_d, next_pc;
    logic [PC_W-2:0]  tag_q, tag_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [WIDTH-1:0] long_q, long_d;
    logic             buf_valid_q, buf_valid_d;
    logic             en_q, en_d;
    logic             mem_rd_q, mem_rd_d;
    logic             choose_q, choose_d;

    assign next_pc = jump_en ? jump_addr : pc_q + PC_W'(1);

    always_comb begin
        state_d     = state_q;
        arm_d       = arm_q;
        pc_d        = pc_q;
        tag_d       = tag_q;
        buf_d       = buf_q;
        long_d      = long_q;
        buf_valid_d = buf_valid_q;
        choose_d    = choose_q;
        en_d        = 1'b0;
        mem_rd_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // arm_q makes IDLE span one full clock after reset release
                if (arm_q) begin
                    state_d  = FETCH;
                    mem_rd_d = 1'b1;
                end else begin
                    arm_d = 1'b1;
                end
            end
            FETCH: begin
                if (mem_valid) begin
                    buf_d       = mem_rdata;
                    tag_d       = pc_q[PC_W-1:1];
                    buf_valid_d = 1'b1;
                    long_d      = mem_rdata;
                    choose_d    = pc_q[0];
                    en_d        = 1'b1;
                    state_d     = ISSUE;
                end else begin
                    mem_rd_d = 1'b1;
                end
            end
            ISSUE, WAIT: begin
                if (done) begin
                    pc_d     = next_pc;
                    choose_d = next_pc[0];
                    if (buf_valid_q && next_pc[PC_W-1:1] == tag_q) begin
                        long_d  = buf_q;
                        en_d    = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        mem_rd_d = 1'b1;
                        state_d  = FETCH;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            arm_q       <= 1'b0;
            pc_q        <= RESET_PC;
            tag_q       <= '0;
            buf_q       <= '0;
            long_q      <= '0;
            buf_valid_q <= 1'b0;
            choose_q    <= RESET_PC[0];
            en_q        <= 1'b0;
            mem_rd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_q       <= arm_d;
            pc_q        <= pc_d;
            tag_q       <= tag_d;
            buf_q       <= buf_d;
            long_q      <= long_d;
            buf_valid_q <= buf_valid_d;
            choose_q    <= choose_d;
            en_q        <= en_d;
            mem_rd_q    <= mem_rd_d;
        end
    end

    assign mem_rd       = mem_rd_q;
    assign mem_addr     = pc_q[PC_W-1:1];
    assign en           = en_q;
    assign long_instr   = long_q;
    assign instr_choose = choose_q;
    assign pc           = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random done/jump/latency traffic
// against a transaction-level model of which word the buffer holds.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        mem_rd;
    logic [14:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        en;
    logic [31:0] long_instr;
    logic        instr_choose;
    logic [15:0] pc;
    logic        done;
    logic        jump_en;
    logic [15:0] jump_addr;

    int n_checks;
    int n_fail;

    logic [15:0] m_pc;
    logic [14:0] m_word;
    logic        m_bv;
    logic [31:0] m_buf;

    instr_fetch #(
        .WIDTH(32),
        .PC_W(16),
        .RESET_PC(16'h0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem_rd(mem_rd),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .mem_valid(mem_valid),
        .en(en),
        .long_instr(long_instr),
        .instr_choose(instr_choose),
        .pc(pc),
        .done(done),
        .jump_en(jump_en),
        .jump_addr(jump_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] memf(input logic [14:0] a);
        return {a, 2'b10, ~a} ^ 32'h3C5A_96E1;
    endfunction

    task automatic check_issue(input string tag);
        check({tag, "_en"}, 32'(en), 1);
        check({tag, "_rd"}, 32'(mem_rd), 0);
        check({tag, "_pc"}, 32'(pc), 32'(m_pc));
        check({tag, "_long"}, long_instr, m_buf);
        check({tag, "_sel"}, 32'(instr_choose), 32'(m_pc[0]));
    endtask

    // DUT is in FETCH at a negedge; respond after lat idle cycles
    task automatic serve(input logic [31:0] data, input int lat);
        for (int i = 0; i < lat; i++) begin
            done      = 1'($urandom_range(0, 1));
            jump_en   = 1'($urandom_range(0, 1));
            jump_addr = 16'($urandom);
            tick();
            check("fetch_hold_rd", 32'(mem_rd), 1);
            check("fetch_hold_addr", 32'(mem_addr), 32'(m_pc[15:1]));
            check("fetch_hold_en", 32'(en), 0);
            check("fetch_hold_pc", 32'(pc), 32'(m_pc));
        end
        done      = 1'b0;
        jump_en   = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = data;
        tick();
        mem_valid = 1'b0;
        mem_rdata = $urandom;
        m_buf  = data;
        m_word = m_pc[15:1];
        m_bv   = 1'b1;
        check_issue("fetched");
    endtask

    // DUT is in ISSUE at a negedge; retire after wc WAIT cycles
    task automatic advance(input bit j, input logic [15:0] ja,
                           input int wc, input int lat);
        logic [15:0] npc;
        for (int i = 0; i < wc; i++) begin
            mem_valid = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            tick();
            check("wait_en", 32'(en), 0);
            check("wait_rd", 32'(mem_rd), 0);
            check("wait_pc", 32'(pc), 32'(m_pc));
            check("wait_long", long_instr, m_buf);
            check("wait_sel", 32'(instr_choose), 32'(m_pc[0]));
        end
        done      = 1'b1;
        jump_en   = j;
        jump_addr = ja;
        tick();
        done      = 1'b0;
        jump_en   = 1'b0;
        mem_valid = 1'b0;
        npc  = j ? ja : m_pc + 16'd1;
        m_pc = npc;
        if (m_bv && npc[15:1] == m_word) begin
            check_issue("reuse");
        end else begin
            check("refetch_rd", 32'(mem_rd), 1);
            check("refetch_addr", 32'(mem_addr), 32'(npc[15:1]));
            check("refetch_en", 32'(en), 0);
            serve(memf(npc[15:1]), lat);
        end
    endtask

    initial begin
        logic [15:0] ja;
        bit          j;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        mem_valid = 1'b0;
        mem_rdata = '0;
        done      = 1'b0;
        jump_en   = 1'b0;
        jump_addr = '0;
        m_pc  = 16'h0000;
        m_word = '0;
        m_bv  = 1'b0;
        m_buf = '0;
        #2;
        check("rst_en", 32'(en), 0);
        check("rst_rd", 32'(mem_rd), 0);
        check("rst_long", long_instr, 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_sel", 32'(instr_choose), 0);

        tick();
        rst_n = 1'b1;
        tick();
        check("idle_rd", 32'(mem_rd), 0);
        tick();
        check("first_rd", 32'(mem_rd), 1);
        check("first_addr", 32'(mem_addr), 0);
        serve(32'hAAAA5555, 2);
        check("r17_long", long_instr, 32'hAAAA5555);
        tick();
        check("r17_single_en", 32'(en), 0);

        advance(1'b0, 16'h0, 1, 1);
        check("r18_pc", 32'(pc), 1);
        check("r18_sel", 32'(instr_choose), 1);
        advance(1'b0, 16'h0, 0, 1);
        check("r22_pc", 32'(pc), 2);
        advance(1'b1, 16'h0000, 1, 0);
        advance(1'b1, 16'h0040, 0, 2);
        check("r19_pc", 32'(pc), 32'h40);
        check("r19_sel", 32'(instr_choose), 0);
        advance(1'b1, 16'h0041, 1, 0);
        check("r13_pc", 32'(pc), 32'h41);
        advance(1'b1, 16'hFFFF, 0, 1);
        advance(1'b0, 16'h0, 1, 1);
        check("r20_pc", 32'(pc), 0);

        done      = 1'b1;
        jump_en   = 1'b1;
        jump_addr = 16'h0300;
        tick();
        done    = 1'b0;
        jump_en = 1'b0;
        check("pre_rst_rd", 32'(mem_rd), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("r21_rd", 32'(mem_rd), 0);
        check("r21_pc", 32'(pc), 0);
        check("r21_long", long_instr, 0);
        tick();
        mem_valid = 1'b1;
        mem_rdata = 32'h12345678;
        tick();
        rst_n = 1'b1;
        tick();
        mem_valid = 1'b0;
        check("r21_stray_en", 32'(en), 0);
        check("r21_stray_long", long_instr, 0);
        check("r21_idle_rd", 32'(mem_rd), 0);
        tick();
        m_pc  = 16'h0000;
        m_bv  = 1'b0;
        m_buf = '0;
        check("r21_resume_rd", 32'(mem_rd), 1);
        check("r21_resume_addr", 32'(mem_addr), 0);
        serve(memf(15'h0), 1);

        for (int k = 0; k < 200; k++) begin
            j  = ($urandom_range(0, 3) == 0);
            ja = 16'($urandom);
            if ($urandom_range(0, 1) == 1) ja[15:1] = m_pc[15:1];
            advance(j, ja, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL take parameters: WIDTH, default 32, memory word and long_instr width; PC_W, default 16, halfword program-counter width; RESET_PC, default 0, pc value loaded at reset.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mem_rd  output  1  instruction-memory read request.
- mem_addr  output  PC_W-1  word address, equal to pc[PC_W-1:1].
- mem_rdata  input  WIDTH  read data.
- mem_valid  input  1  mem_rdata is valid this cycle.
- en  output  1  one-cycle strobe to instr_decode: instruction presented.
- long_instr  output  WIDTH  buffered instruction word.
- instr_choose  output  1  halfword select, equal to pc[0]: 0 selects [15:0], 1 selects [31:16].
- pc  output  PC_W  halfword address of the presented instruction.
- done  input  1  downstream has retired the presented instruction.
- jump_en  input  1  take a jump on this done.
- jump_addr  input  PC_W  halfword jump target.

Function
REQ-003 The block SHALL implement the states IDLE, FETCH, ISSUE and WAIT.
REQ-004 IDLE SHALL last exactly one cycle after reset release and then go to FETCH unconditionally.
REQ-005 In FETCH:
- mem_rd=1, with mem_addr held stable until mem_valid.
- On mem_valid: latch mem_rdata into the buffer, set tag=mem_addr, set buf_valid=1, go to ISSUE.
- mem_rd SHALL drop in the cycle after mem_valid.
REQ-006 mem_valid outside FETCH SHALL be ignored; it SHALL change neither the buffer nor the state.
REQ-007 In ISSUE:
- en=1 for exactly that cycle.
- long_instr=buffer, instr_choose=pc[0].
- Next state is WAIT unless done=1 in the same cycle, in which case REQ-009 applies.
REQ-008 In WAIT, en=0 and long_instr, instr_choose and pc SHALL hold; the block SHALL stay in WAIT until done=1.
REQ-009 When done=1 in ISSUE or WAIT:
- next_pc = jump_addr if jump_en=1, else pc+1 (modulo 2^PC_W, so all-ones wraps to 0).
- pc <= next_pc.
- If buf_valid=1 and next_pc[PC_W-1:1]=tag: go to ISSUE with no memory access.
- Otherwise go to FETCH.
REQ-010 done and jump_en SHALL be ignored in IDLE and FETCH.
REQ-011 Latency:
- mem_valid to en: 1 cycle.
- done to next en, same word: 1 cycle.
- done to next en, new word: 1 cycle plus the memory latency.
REQ-012 A sequential halfword pair in one word SHALL cost one memory read; crossing a word boundary (pc[0] 1->0) SHALL force FETCH.
REQ-013 A jump whose target lies in the buffered word SHALL reuse the buffer.

Reset
REQ-014 While rst_n=0, the block SHALL asynchronously force:
- state=IDLE, pc=RESET_PC, buf_valid=0, buffer=0, tag=0.
- en=0, mem_rd=0, long_instr=0, instr_choose=RESET_PC[0].
REQ-015 Reset asserted mid-FETCH SHALL drop mem_rd immediately and abandon the read; a mem_valid arriving later SHALL be ignored per REQ-006.
REQ-016 After rst_n rises, the first mem_rd SHALL assert in the second rising edge's cycle (IDLE then FETCH).

Verification
REQ-017 Reset then mem_valid after 3 cycles with 0xAAAA5555 -> mem_addr=0; en pulses once with long_instr=0xAAAA5555, instr_choose=0, pc=0.
REQ-018 done (jump_en=0) in WAIT at pc=0 -> next cycle en=1, pc=1, instr_choose=1, no mem_rd; next done -> FETCH with mem_addr=1.
REQ-019 done with jump_en=1, jump_addr=0x0040 while buffer tag=0 -> FETCH with mem_addr=0x0020; after mem_valid, pc=0x0040, instr_choose=0.
REQ-020 pc=0xFFFF, done (no jump) -> pc=0x0000, FETCH with mem_addr=0.
REQ-021 rst_n pulsed low while mem_rd=1, then a stray mem_valid with 0x12345678 -> mem_rd=0 at once, no en, buffer stays 0; normal fetch resumes from RESET_PC.
REQ-022 done asserted in the ISSUE cycle, and done/jump_en pulsed during FETCH -> done in ISSUE advances pc with no WAIT cycle; done/jump_en during FETCH leave pc unchanged.
